trivium_ser_host: RTL and testbench

//  Host-side driver for the bit-serial trivium_top core interface (dat_i/init_i/end_i in, dat_o out).

---
 rtl/trivium_ser_host.sv | 211 +++++++++++++++++++++
 tb/tb_trivium_ser_host.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_ser_host.sv
// Host-side bit-serial driver for trivium_top: loads key/IV, streams plaintext words, rebuilds ciphertext words.
// Optional READY-gap counter output gap_cnt_o is built when TRIV_HOST_GAPCNT_EN is defined.
module trivium_ser_host #(
  parameter int WARMUP_CYCLES = 1152,
  parameter int CORE_LAT      = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  output logic        busy_o,
  input  logic [31:0] pt_dat_i,
  input  logic        pt_last_i,
  input  logic        pt_vld_i,
  output logic        pt_rdy_o,
  output logic [31:0] ct_dat_o,
  output logic        ct_vld_o,
  output logic        core_dat_o,
  output logic        core_init_o,
  output logic        core_end_o,
  input  logic        core_dat_i
`ifdef TRIV_HOST_GAPCNT_EN
  ,
  output logic [15:0] gap_cnt_o
`endif
);

  localparam int CNT_MAX = (WARMUP_CYCLES > 80) ? WARMUP_CYCLES : 80;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(79);
  localparam logic [CW-1:0] BIT_LAST   = CW'(31);
  localparam logic [CW-1:0] WARM_INIT  = CW'(WARMUP_CYCLES);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(CORE_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_IV,
    ST_WARMUP,
    ST_READY,
    ST_STREAM,
    ST_FLUSH,
    ST_END
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_start;
  logic          xfer;

  logic [79:0]   key_q;
  logic [79:0]   iv_q;
  logic [31:0]   word_q;
  logic          last_q;

  logic [CORE_LAT-1:0] cap_vld_q;
  logic [4:0]          cap_idx_q [CORE_LAT];
  logic [30:0]         ct_acc_q;
  logic                tap_vld;
  logic [4:0]          tap_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_o       = (state_q != ST_IDLE);
    pt_rdy_o     = 1'b0;
    core_dat_o   = 1'b0;
    core_init_o  = 1'b0;
    core_end_o   = 1'b0;
    accept_start = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept_start = 1'b1;
          state_d      = ST_LOAD_KEY;
          cnt_d        = '0;
        end
      end
      ST_LOAD_KEY: begin
        core_init_o = 1'b1;
        core_dat_o  = key_q[0];
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_LOAD_IV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_LOAD_IV: begin
        core_init_o = 1'b1;
        core_dat_o  = iv_q[0];
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_WARMUP;
          cnt_d   = WARM_INIT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_WARMUP: begin
        if (cnt_q == ONE) state_d = ST_READY;
        else              cnt_d   = cnt_q - ONE;
      end
      ST_READY: begin
        pt_rdy_o = 1'b1;
        if (pt_vld_i) begin
          xfer    = 1'b1;
          state_d = ST_STREAM;
          cnt_d   = '0;
        end
      end
      ST_STREAM: begin
        core_dat_o = word_q[0];
        if (cnt_q == BIT_LAST) begin
          if (last_q) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end else begin
            // Accepting the next word on bit 31 gives zero-gap back-to-back streaming.
            pt_rdy_o = 1'b1;
            if (pt_vld_i) begin
              xfer  = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = ST_READY;
            end
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) state_d = ST_END;
        else                     cnt_d   = cnt_q + ONE;
      end
      ST_END: begin
        core_end_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: key/IV/word holding registers carry no reset; each is loaded before the FSM ever reads it.
  always_ff @(posedge clk_i) begin
    if (accept_start) begin
      key_q <= key_i;
      iv_q  <= iv_i;
    end else begin
      if (state_q == ST_LOAD_KEY) key_q <= {1'b0, key_q[79:1]};
      if (state_q == ST_LOAD_IV)  iv_q  <= {1'b0, iv_q[79:1]};
    end
    if (xfer) begin
      word_q <= pt_dat_i;
      last_q <= pt_last_i;
    end else if (state_q == ST_STREAM) begin
      word_q <= {1'b0, word_q[31:1]};
    end
  end

  assign tap_vld = cap_vld_q[CORE_LAT-1];
  assign tap_idx = cap_idx_q[CORE_LAT-1];

  // Each driven data bit travels CORE_LAT stages with its index, lining up with the core's reply.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_vld_q <= '0;
      for (int i = 0; i < CORE_LAT; i++) cap_idx_q[i] <= '0;
      ct_acc_q  <= '0;
      ct_dat_o  <= '0;
      ct_vld_o  <= 1'b0;
    end else begin
      cap_vld_q[0] <= (state_q == ST_STREAM);
      cap_idx_q[0] <= cnt_q[4:0];
      for (int i = 1; i < CORE_LAT; i++) begin
        cap_vld_q[i] <= cap_vld_q[i-1];
        cap_idx_q[i] <= cap_idx_q[i-1];
      end
      ct_vld_o <= tap_vld && (tap_idx == 5'd31);
      if (tap_vld) begin
        if (tap_idx == 5'd31) ct_dat_o <= {core_dat_i, ct_acc_q};
        else                  ct_acc_q[tap_idx] <= core_dat_i;
      end
    end
  end

`ifdef TRIV_HOST_GAPCNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || accept_start) begin
      gap_cnt_o <= '0;
    end else if (state_q == ST_READY && !pt_vld_i && gap_cnt_o != 16'hFFFF) begin
      gap_cnt_o <= gap_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trivium_ser_host.sv
// Self-checking bench for trivium_ser_host: LFSR keystream core model, cycle-timeline scoreboard, directed pins.
// Build with TRIV_HOST_GAPCNT_EN defined to also check gap_cnt_o.
module tb_trivium_ser_host;

  localparam int W = 1152;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [79:0] key_i;
  logic [79:0] iv_i;
  logic        busy_o;
  logic [31:0] pt_dat_i;
  logic        pt_last_i;
  logic        pt_vld_i;
  logic        pt_rdy_o;
  logic [31:0] ct_dat_o;
  logic        ct_vld_o;
  logic        core_dat_o;
  logic        core_init_o;
  logic        core_end_o;
  logic        core_dat_i;
`ifdef TRIV_HOST_GAPCNT_EN
  logic [15:0] gap_cnt_o;
`endif

  always #5 clk = ~clk;

  trivium_ser_host #(.WARMUP_CYCLES(W), .CORE_LAT(L)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .key_i       (key_i),
    .iv_i        (iv_i),
    .busy_o      (busy_o),
    .pt_dat_i    (pt_dat_i),
    .pt_last_i   (pt_last_i),
    .pt_vld_i    (pt_vld_i),
    .pt_rdy_o    (pt_rdy_o),
    .ct_dat_o    (ct_dat_o),
    .ct_vld_o    (ct_vld_o),
    .core_dat_o  (core_dat_o),
    .core_init_o (core_init_o),
    .core_end_o  (core_end_o),
    .core_dat_i  (core_dat_i)
`ifdef TRIV_HOST_GAPCNT_EN
    ,
    .gap_cnt_o   (gap_cnt_o)
`endif
  );

  // Core model: dat_o = dat_i ^ ks, delayed L cycles; ks from a free-running LFSR.
  logic [31:0]  lfsr = 32'hACE1_1234;
  logic         ks_en;
  logic         ks_bit;
  logic [L-1:0] core_pipe = '0;
  assign ks_bit     = ks_en & lfsr[0];
  assign core_dat_i = core_pipe[L-1];
  always @(posedge clk) begin
    core_pipe <= {core_pipe[L-2:0], core_dat_o ^ ks_bit};
    lfsr      <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a session timeline derived from the start cycle and each word transfer cycle.
  typedef struct {int due; int first; logic [31:0] pt;} ct_exp_t;
  typedef struct {int c; logic [31:0] d;} ct_obs_t;

  bit          sess = 1'b0;
  int          s_cyc = 0;
  bit          last_seen = 1'b0;
  int          end_cyc = -1;
  int          blk_until = -1;
  int          last_b31 = -1;
  int          gap_m = 0;
  logic [79:0] m_key = '0;
  logic [79:0] m_iv = '0;
  bit          exp_bit[int];
  bit          ks_hist[int];
  ct_exp_t     ctq[$];
  ct_obs_t     ct_log[$];
  int          end_log[$];
  int          xfer_log[$];

  always @(negedge clk) begin : monitor
    bit          e_init, e_dat, e_rdy, e_busy, e_end, e_vld, acc_start;
    logic [31:0] e_ct;
    int          off;
    ks_hist[cyc] = ks_bit;
    off    = cyc - s_cyc - 1;
    e_init = sess && off >= 0 && off < 160;
    if (e_init) e_dat = (off < 80) ? m_key[off] : m_iv[off-80];
    else        e_dat = exp_bit.exists(cyc) ? exp_bit[cyc] : 1'b0;
    e_rdy  = sess && !last_seen && cyc >= s_cyc + 161 + W && cyc > blk_until;
    e_busy = sess && off >= 0;
    e_end  = sess && last_seen && cyc == end_cyc;
    e_vld  = ctq.size() > 0 && ctq[0].due == cyc;

    check("busy_o", busy_o, e_busy);
    check("pt_rdy_o", pt_rdy_o, e_rdy);
    check("core_init_o", core_init_o, e_init);
    check("core_dat_o", core_dat_o, e_dat);
    check("core_end_o", core_end_o, e_end);
    check("ct_vld_o", ct_vld_o, e_vld);
    if (e_vld) begin
      e_ct = ctq[0].pt;
      for (int k = 0; k < 32; k++) e_ct[k] = e_ct[k] ^ ks_hist[ctq[0].first + k];
      check("ct_dat_o", ct_dat_o, e_ct);
      void'(ctq.pop_front());
    end
`ifdef TRIV_HOST_GAPCNT_EN
    check("gap_cnt_o", gap_cnt_o, gap_m);
`endif
    if (ct_vld_o)   ct_log.push_back('{cyc, ct_dat_o});
    if (core_end_o) end_log.push_back(cyc);

    if (rst_i) begin
      sess = 1'b0; last_seen = 1'b0; gap_m = 0;
      ctq.delete(); exp_bit.delete();
    end else begin
      acc_start = !sess && start_i;
      if (e_rdy && pt_vld_i) begin
        for (int k = 0; k < 32; k++) exp_bit[cyc + 1 + k] = pt_dat_i[k];
        ctq.push_back('{cyc + 33 + L, cyc + 1, pt_dat_i});
        xfer_log.push_back(cyc);
        blk_until = cyc + 31;
        last_b31  = cyc + 32;
        if (pt_last_i) begin
          last_seen = 1'b1;
          end_cyc   = cyc + 33 + L;
        end
      end
      if (e_rdy && !pt_vld_i && cyc != last_b31 && gap_m < 65535) gap_m++;
      if (e_end) sess = 1'b0;
      if (acc_start) begin
        sess = 1'b1; s_cyc = cyc; last_seen = 1'b0;
        blk_until = -1; last_b31 = -1; gap_m = 0;
        m_key = key_i; m_iv = iv_i;
      end
    end
  end

  // Stimulus: inputs change 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ct_log.delete();
    end_log.delete();
    xfer_log.delete();
  endtask

  task automatic start_session(input logic [79:0] k, input logic [79:0] v);
    start_i = 1'b1; key_i = k; iv_i = v;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_rdy(input int budget);
    for (int i = 0; i < budget && !pt_rdy_o; i++) tick();
    check("pt_rdy_wait", pt_rdy_o, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit last);
    pt_dat_i = w; pt_last_i = last; pt_vld_i = 1'b1;
    wait_rdy(200);
    tick();
    pt_vld_i = 1'b0; pt_last_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy_o; i++) tick();
    check("busy_after_end", busy_o, 1'b0);
  endtask

  function automatic logic [79:0] rand80();
    return {$urandom_range(65535, 0), $urandom(), $urandom()};
  endfunction

  initial begin
    int n_init, n_ones, one_at, n_warm, n_busy_lo;
    logic [31:0] w;
    rst_i = 1'b1; start_i = 1'b0; key_i = '0; iv_i = '0;
    pt_dat_i = '0; pt_last_i = 1'b0; pt_vld_i = 1'b0; ks_en = 1'b0;
    tick();
    rst_i = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_pt_rdy", pt_rdy_o, 1'b0);
    check("rst_ct_vld", ct_vld_o, 1'b0);
    check("rst_ct_dat", ct_dat_o, 32'h0);
    check("rst_core_init", core_init_o, 1'b0);
    check("rst_core_end", core_end_o, 1'b0);
    repeat (3) tick();

    // Session 1: key=1, iv=0, zero keystream, two back-to-back words.
    ks_en = 1'b0;
    clear_logs();
    start_session(80'h1, 80'h0);
    n_init = 0; n_ones = 0; one_at = -1; n_warm = 0; n_busy_lo = 0;
    for (int i = 0; i < W + 400 && !pt_rdy_o; i++) begin
      if (core_init_o) begin
        n_init++;
        if (core_dat_o) begin
          n_ones++;
          if (one_at < 0) one_at = i;
        end
      end else begin
        n_warm++;
      end
      if (!busy_o) n_busy_lo++;
      tick();
    end
    check("init_cycles", n_init, 160);
    check("key_one_count", n_ones, 1);
    check("key_one_pos", one_at, 0);
    check("warmup_rdy_low", n_warm, W);
    check("busy_during_setup", n_busy_lo, 0);
    check("rdy_after_warmup", pt_rdy_o, 1'b1);
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'h01234567, 1'b1);
    wait_idle();
    check("ks0_ct_count", ct_log.size(), 2);
    check("ks0_end_pulses", end_log.size(), 1);
    if (ct_log.size() == 2 && xfer_log.size() == 2) begin
      check("ks0_ct0", ct_log[0].d, 32'hDEADBEEF);
      check("ks0_ct1", ct_log[1].d, 32'h01234567);
      check("ks0_ct_spacing", ct_log[1].c - ct_log[0].c, 32);
      // ct_vld_o rises 32+L edges after the transfer edge, i.e. 33+L cycles after the transfer cycle.
      check("ks0_first_latency", ct_log[0].c - xfer_log[0], 33 + L);
    end

    // Session 2: LFSR keystream, four words with 3-cycle READY gaps.
    ks_en = 1'b1;
    clear_logs();
    start_session(rand80(), rand80());
    wait_rdy(W + 400);
    for (int j = 0; j < 4; j++) begin
      send_word($urandom(), j == 3);
      if (j < 3) begin
        wait_rdy(64);
        repeat (4) tick();
      end
    end
    for (int i = 0; i < 100 && !core_end_o; i++) tick();
    check("gaps_end_seen", core_end_o, 1'b1);
`ifdef TRIV_HOST_GAPCNT_EN
    check("gaps_gap_cnt", gap_cnt_o, 16'd9);
`endif
    wait_idle();
    check("gaps_ct_count", ct_log.size(), 4);

    // Session 3: reset while streaming bit 10.
    clear_logs();
    start_session(rand80(), rand80());
    wait_rdy(W + 400);
    send_word($urandom(), 1'b0);
    repeat (10) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_pt_rdy", pt_rdy_o, 1'b0);
    check("mrst_core_dat", core_dat_o, 1'b0);
    check("mrst_core_init", core_init_o, 1'b0);
    check("mrst_ct_dat", ct_dat_o, 32'h0);
    repeat (50) tick();
    check("mrst_no_ct", ct_log.size(), 0);
    check("mrst_no_end", end_log.size(), 0);

    // Session 4: pt_vld during warmup and start_i during streaming are both ignored.
    clear_logs();
    start_session(rand80(), rand80());
    for (int i = 0; i < 200 && core_init_o; i++) tick();
    pt_dat_i = $urandom(); pt_vld_i = 1'b1;
    repeat (20) tick();
    pt_vld_i = 1'b0;
    check("warmup_no_xfer", xfer_log.size(), 0);
    wait_rdy(W + 400);
    for (int j = 0; j < 3; j++) begin
      repeat ($urandom_range(4, 0)) tick();
      w = $urandom();
      send_word(w, j == 2);
      if (j == 0) begin
        repeat (3) tick();
        start_i = 1'b1; key_i = rand80(); iv_i = rand80();
        tick();
        start_i = 1'b0;
      end
    end
    wait_idle();
    check("ign_ct_count", ct_log.size(), 3);
    check("ign_end_pulses", end_log.size(), 1);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active after 1 ms, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
